// File: rtl/keypad_scan_pkg.sv
// Shared constants, FSM state type and bit-counting helpers for the 4x4 keypad scanner.
package keypad_scan_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        MULTI   = 2'd2
    } kp_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // Index of the set bit; bit c*4+r maps straight to the code {col,row}.
    function automatic logic [3:0] onehot16_to_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; RESET_VAL sets the idle level.
module keypad_scan_sync2 #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: column strobing, full-matrix debounce, single-key event
// reporting with a valid/ack handshake.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_ROWS-1:0] row_n,
    output logic [KP_COLS-1:0] col_n,
    output logic [3:0]         key_code,
    output logic               key_valid,
    input  logic               key_ack,
    output logic               key_down,
    output logic               key_overrun,
    output kp_state_e          state_dbg
);

    // Handshake: key_valid rises the edge after an event and stays high until the
    // edge after key_ack is sampled high; an event in the ack cycle keeps it high.

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);

    logic [KP_ROWS-1:0] row_sync;
    logic [KP_ROWS-1:0] rows_now;
    logic [DIV_W-1:0]   div;
    logic [1:0]         col;
    logic [KP_KEYS-1:0] snapshot;
    logic [KP_KEYS-1:0] frame;
    logic [KP_KEYS-1:0] prev;
    logic [KP_KEYS-1:0] held;
    logic [STB_W-1:0]   stable;
    logic [STB_W-1:0]   stable_nxt;
    logic               col_tick;
    logic               frame_end;
    logic               frame_same;
    logic               accept;
    kp_state_e          state;

    keypad_scan_sync2 #(
        .W         (KP_ROWS),
        .RESET_VAL ({KP_ROWS{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_sync)
    );

    assign rows_now   = ~row_sync;
    assign col_tick   = (div == DIV_LAST);
    assign frame_end  = col_tick && (col == 2'd3);
    assign col_n      = ~(KP_COLS'(1) << col);
    assign frame_same = (frame == prev);
    assign accept     = frame_end && (stable_nxt == STB_MAX);
    assign state_dbg  = state;

    // Snapshot with the current column's rows merged in; at frame end this is the whole matrix.
    always_comb begin
        frame = snapshot;
        frame[{col, 2'b00} +: KP_ROWS] = rows_now;
    end

    always_comb begin
        stable_nxt = STB_W'(1);
        if (frame_same) begin
            stable_nxt = (stable == STB_MAX) ? stable : stable + STB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            col      <= '0;
            snapshot <= '0;
            prev     <= '0;
            stable   <= '0;
        end else begin
            if (col_tick) begin
                div      <= '0;
                col      <= col + 2'd1;
                snapshot <= frame;
            end else begin
                div <= div + DIV_W'(1);
            end
            if (frame_end) begin
                stable <= stable_nxt;
                if (!frame_same) prev <= frame;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            held        <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            // The event assignment below is later in the block, so it wins over a same-cycle ack.
            if (key_ack) key_valid <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (popcount16(frame) == 5'd1) begin
                            state     <= PRESSED;
                            held      <= frame;
                            key_down  <= 1'b1;
                            key_code  <= onehot16_to_idx(frame);
                            key_valid <= 1'b1;
                            if (key_valid && !key_ack) key_overrun <= 1'b1;
                        end else if (popcount16(frame) > 5'd1) begin
                            state <= MULTI;
                        end
                    end
                    PRESSED: begin
                        if (frame == '0) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end else if (frame != held) begin
                            state    <= MULTI;
                            key_down <= 1'b0;
                        end
                    end
                    MULTI: begin
                        if (frame == '0) state <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        key_down <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed frame table, mid-scan reset, then random frames
// checked against a frame-level model of the debounce and key-event rules.
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       key_overrun;
  kp_state_e  state_dbg;

  logic [15:0] pressed;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] m;
    int          ack;
    logic        valid;
    logic [3:0]  code;
    logic        down;
    logic        ovr;
    kp_state_e   st;
  } vec_t;

  vec_t tbl[$];

  // frame-level reference model
  logic [15:0] m_prev;
  int          m_stable;
  int          m_mode;   // 0 none, 1 single key held, 2 chord
  logic [15:0] m_held;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_ovr;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_down    (key_down),
    .key_overrun (key_overrun),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // physical matrix: a pressed key shorts its column strobe onto its row
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_n[c]) row_n = row_n & ~pressed[c*4 +: 4];
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] m, input int ack, input logic v,
                              input logic [3:0] c, input logic d, input logic o,
                              input kp_state_e s);
    vec_t r;
    r.m = m; r.ack = ack; r.valid = v; r.code = c; r.down = d; r.ovr = o; r.st = s;
    return r;
  endfunction

  function automatic int count_keys(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] key_index(input logic [15:0] m);
    logic [3:0] idx = 4'd0;
    for (int i = 0; i < 16; i++) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_stable = 0; m_mode = 0; m_held = '0;
    m_valid = 1'b0; m_code = '0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [15:0] m, input int ack);
    bit ev = 0;
    int n;
    if (ack == 1) m_valid = 1'b0;
    if (m == m_prev) begin
      if (m_stable < DEB) m_stable++;
    end else begin
      m_stable = 1;
      m_prev   = m;
    end
    if (m_stable == DEB) begin
      n = count_keys(m);
      if (m_mode == 0) begin
        if (n == 1) begin m_mode = 1; m_held = m; ev = 1; end
        else if (n > 1) m_mode = 2;
      end else if (m_mode == 1) begin
        if (n == 0) m_mode = 0;
        else if (m != m_held) m_mode = 2;
      end else if (n == 0) begin
        m_mode = 0;
      end
    end
    if (ev) begin
      if (m_valid && ack != 2) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_code  = key_index(m);
    end else if (ack == 2) begin
      m_valid = 1'b0;
    end
  endtask

  // driver: called at the negedge where a new frame has just begun (div=0, col=0).
  // ack 1 pulses key_ack mid-frame, ack 2 pulses it in the frame-end cycle.
  task automatic run_frame(input logic [15:0] m, input int ack);
    logic [3:0] exp_col;
    pressed = m;
    for (int k = 0; k < 16; k++) begin
      key_ack = (ack == 1 && k == 5) || (ack == 2 && k == 15);
      @(posedge clk);
      @(negedge clk);
      key_ack = 1'b0;
      exp_col = 4'hF ^ (4'h1 << (((k + 1) / 4) % 4));
      chk("col_n", 16'(col_n), 16'(exp_col));
      if (ack == 1 && k == 5) chk("valid_after_ack", 16'(key_valid), 16'd0);
    end
    model_frame(m, ack);
  endtask

  task automatic check_vs_model(input string tag);
    kp_state_e exp_st;
    exp_st = (m_mode == 1) ? PRESSED : (m_mode == 2) ? MULTI : IDLE;
    chk({tag, "_valid"},   16'(key_valid),   16'(m_valid));
    chk({tag, "_code"},    16'(key_code),    16'(m_code));
    chk({tag, "_down"},    16'(key_down),    16'(m_mode == 1));
    chk({tag, "_overrun"}, 16'(key_overrun), 16'(m_ovr));
    chk({tag, "_state"},   16'(state_dbg),   16'(exp_st));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col_n"},   16'(col_n),       16'hE);
    chk({tag, "_code"},    16'(key_code),    16'd0);
    chk({tag, "_valid"},   16'(key_valid),   16'd0);
    chk({tag, "_down"},    16'(key_down),    16'd0);
    chk({tag, "_overrun"}, 16'(key_overrun), 16'd0);
    chk({tag, "_state"},   16'(state_dbg),   16'(IDLE));
  endtask

  initial begin
    logic [15:0] m;
    int hold;
    int r;
    int ack;
    bit found;

    rst_n   = 1'b0;
    key_ack = 1'b0;
    pressed = '0;
    model_reset();

    // directed frames: {matrix, ack, valid, code, down, overrun, state}
    for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0000, 0, 0, 4'h0, 0, 0, IDLE));
    tbl.push_back(mk(16'h0040, 0, 0, 4'h0, 0, 0, IDLE));
    tbl.push_back(mk(16'h0040, 0, 0, 4'h0, 0, 0, IDLE));
    tbl.push_back(mk(16'h0040, 0, 1, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0040, 1, 0, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 1, 0, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 0, 0, IDLE));
    // bounce: key toggles each frame, then holds
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk((i % 2 == 0) ? 16'h0040 : 16'h0000, 0, 0, 4'h6, 0, 0, IDLE));
    tbl.push_back(mk(16'h0040, 0, 0, 4'h6, 0, 0, IDLE));
    tbl.push_back(mk(16'h0040, 0, 1, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0040, 1, 0, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 0, 0, IDLE));
    // chord col0/row0 + col2/row1
    tbl.push_back(mk(16'h0201, 0, 0, 4'h6, 0, 0, IDLE));
    tbl.push_back(mk(16'h0201, 0, 0, 4'h6, 0, 0, IDLE));
    tbl.push_back(mk(16'h0201, 0, 0, 4'h6, 0, 0, MULTI));
    tbl.push_back(mk(16'h0201, 0, 0, 4'h6, 0, 0, MULTI));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 0, 0, MULTI));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 0, 0, MULTI));
    tbl.push_back(mk(16'h0000, 0, 0, 4'h6, 0, 0, IDLE));
    tbl.push_back(mk(16'h8000, 0, 0, 4'h6, 0, 0, IDLE));
    tbl.push_back(mk(16'h8000, 0, 0, 4'h6, 0, 0, IDLE));
    tbl.push_back(mk(16'h8000, 0, 1, 4'hF, 1, 0, PRESSED));
    tbl.push_back(mk(16'h8000, 0, 1, 4'hF, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 1, 4'hF, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 1, 4'hF, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 1, 4'hF, 0, 0, IDLE));
    // event coincident with ack: valid stays, no overrun
    tbl.push_back(mk(16'h0002, 0, 1, 4'hF, 0, 0, IDLE));
    tbl.push_back(mk(16'h0002, 0, 1, 4'hF, 0, 0, IDLE));
    tbl.push_back(mk(16'h0002, 2, 1, 4'h1, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 1, 4'h1, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 1, 4'h1, 1, 0, PRESSED));
    tbl.push_back(mk(16'h0000, 0, 1, 4'h1, 0, 0, IDLE));
    // overrun: new event while still pending
    tbl.push_back(mk(16'h0010, 0, 1, 4'h1, 0, 0, IDLE));
    tbl.push_back(mk(16'h0010, 0, 1, 4'h1, 0, 0, IDLE));
    tbl.push_back(mk(16'h0010, 0, 1, 4'h4, 1, 1, PRESSED));

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_frame(tbl[i].m, tbl[i].ack);
      chk($sformatf("tbl%0d_valid", i),   16'(key_valid),   16'(tbl[i].valid));
      chk($sformatf("tbl%0d_code", i),    16'(key_code),    16'(tbl[i].code));
      chk($sformatf("tbl%0d_down", i),    16'(key_down),    16'(tbl[i].down));
      chk($sformatf("tbl%0d_overrun", i), 16'(key_overrun), 16'(tbl[i].ovr));
      chk($sformatf("tbl%0d_state", i),   16'(state_dbg),   16'(tbl[i].st));
    end

    // reset during col2 with a key held, then a fresh debounce is needed
    run_frame(16'h0040, 0);
    check_vs_model("prereset1");
    run_frame(16'h0040, 0);
    check_vs_model("prereset2");
    found = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      if (col_n == 4'b1011) found = 1;
    end
    chk("col2_reached", 16'(found), 16'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      run_frame(16'h0040, 0);
      check_vs_model($sformatf("postreset%0d", i));
    end
    chk("postreset_code", 16'(key_code), 16'h6);

    // random frames against the model
    m = '0;
    for (int f = 0; f < 60; ) begin
      r = $urandom_range(0, 3);
      case (r)
        0: m = '0;
        1: m = 16'h1 << $urandom_range(0, 15);
        2: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: ;
      endcase
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        ack = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        run_frame(m, ack);
        check_vs_model($sformatf("rand%0d", f));
        f++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
